// File: rtl/flow_handler_fifo.sv
// Dual-rail two-phase toggle handshake receiver, DEPTH-entry FIFO, and toggle-protocol sender.
// Tokens pass through in strict order. There is no pass-through path when the FIFO is full.
module flow_handler_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  in_diff_pair_p,
  input  logic                  in_diff_pair_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ack_p,
  output logic                  in_ack_n,
  output logic                  in_pipe_en,
  output logic                  out_diff_pair_p,
  output logic                  out_diff_pair_n,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ack_p,
  input  logic                  out_ack_n,
  output logic [CNT_WIDTH-1:0]  fifo_count,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

  logic                  expected_p_r;
  logic                  expected_n_r;
  logic                  out_p_r;
  logic                  out_n_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_r;
  logic [PTR_WIDTH-1:0]  rd_ptr_r;
  logic [CNT_WIDTH-1:0]  count_r;
  logic                  full_r;
  logic                  empty_r;

  logic                  pending_s;
  logic                  push_s;
  logic                  outstanding_s;
  logic                  pop_s;
  logic [CNT_WIDTH-1:0]  count_next_s;

  // A token needs both rails flipped relative to the expected phase.
  // A single-rail flip is ignored.
  assign pending_s     = (in_diff_pair_p ^ expected_p_r) & (in_diff_pair_n ^ expected_n_r);
  assign push_s        = pending_s & ~full_r;
  assign outstanding_s = (out_p_r != out_ack_p) | (out_n_r != out_ack_n);
  assign pop_s         = ~outstanding_s & ~empty_r;

  // Occupancy next-state from push/pop pairing
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_WIDTH'(1);
      2'b01:   count_next_s = count_r - CNT_WIDTH'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Upstream phase tracking: the expected registers double as the acknowledge
  always_ff @(posedge clka) begin
    if (!rsta) begin
      expected_p_r <= 1'b1;
      expected_n_r <= 1'b0;
    end else if (push_s) begin
      expected_p_r <= ~expected_p_r;
      expected_n_r <= ~expected_n_r;
    end else begin
      expected_p_r <= expected_p_r;
      expected_n_r <= expected_n_r;
    end
  end

  // FIFO storage and write pointer
  always_ff @(posedge clka) begin
    if (!rsta) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
      wr_ptr_r        <= wr_ptr_r + PTR_WIDTH'(1);
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Downstream sender: a new token launches once the previous one is fully acknowledged
  always_ff @(posedge clka) begin
    if (!rsta) begin
      out_p_r    <= 1'b1;
      out_n_r    <= 1'b0;
      out_data_r <= '0;
      rd_ptr_r   <= '0;
    end else if (pop_s) begin
      out_p_r    <= ~out_p_r;
      out_n_r    <= ~out_n_r;
      out_data_r <= mem_r[rd_ptr_r];
      rd_ptr_r   <= rd_ptr_r + PTR_WIDTH'(1);
    end else begin
      out_p_r    <= out_p_r;
      out_n_r    <= out_n_r;
      out_data_r <= out_data_r;
      rd_ptr_r   <= rd_ptr_r;
    end
  end

  // Occupancy and registered full/empty flags
  always_ff @(posedge clka) begin
    if (!rsta) begin
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      count_r <= count_next_s;
      full_r  <= (count_next_s == DEPTH_C);
      empty_r <= (count_next_s == CNT_WIDTH'(0));
    end
  end

  assign in_ack_p        = expected_p_r;
  assign in_ack_n        = expected_n_r;
  assign in_pipe_en      = push_s;
  assign out_diff_pair_p = out_p_r;
  assign out_diff_pair_n = out_n_r;
  assign out_data        = out_data_r;
  assign fifo_count      = count_r;
  assign full            = full_r;
  assign empty           = empty_r;

endmodule

// File: tb/tb_flow_handler_fifo.sv
// Directed bench for flow_handler_fifo: reset, single token, back-pressure,
// ordering with random ack delay, partial rail, and reset mid-operation.
module tb_flow_handler_fifo;

  logic        clka = 1'b0;
  logic        rsta;
  logic        in_p, in_n;
  logic [15:0] in_data;
  logic        in_ack_p, in_ack_n, in_pipe_en;
  logic        out_diff_pair_p, out_diff_pair_n;
  logic [15:0] out_data;
  logic        out_ack_p, out_ack_n;
  logic [2:0]  fifo_count;
  logic        full, empty;
  logic        auto_ack, man_ack_p, man_ack_n;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  always #5 clka = ~clka;

  // Downstream peer: instant ack when auto_ack is set, otherwise manual rails
  assign out_ack_p = auto_ack ? out_diff_pair_p : man_ack_p;
  assign out_ack_n = auto_ack ? out_diff_pair_n : man_ack_n;

  flow_handler_fifo #(.DATA_WIDTH(16), .DEPTH(4)) dut (
    .clka(clka), .rsta(rsta),
    .in_diff_pair_p(in_p), .in_diff_pair_n(in_n), .in_data(in_data),
    .in_ack_p(in_ack_p), .in_ack_n(in_ack_n), .in_pipe_en(in_pipe_en),
    .out_diff_pair_p(out_diff_pair_p), .out_diff_pair_n(out_diff_pair_n),
    .out_data(out_data), .out_ack_p(out_ack_p), .out_ack_n(out_ack_n),
    .fifo_count(fifo_count), .full(full), .empty(empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ack"},  {30'd0, in_ack_p, in_ack_n}, 32'd2);
    chk({tag, "_out_rail"}, {30'd0, out_diff_pair_p, out_diff_pair_n}, 32'd2);
    chk({tag, "_count"},   {29'd0, fifo_count}, 32'd0);
    chk({tag, "_empty"},   {31'd0, empty}, 32'd1);
    chk({tag, "_full"},    {31'd0, full}, 32'd0);
    chk({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
  endtask

  initial begin
    int snt, rcv, dly, max_cnt;
    logic prev_p;
    rsta = 1'b0; in_p = 1'b1; in_n = 1'b0; in_data = 16'h0000;
    auto_ack = 1'b1; man_ack_p = 1'b1; man_ack_n = 1'b0;
    tick(); tick();
    chk_reset_state("reset");
    rsta = 1'b1;

    // Single token, instant downstream ack
    in_p = 1'b0; in_n = 1'b1; in_data = 16'hA5A5;
    #1 chk("single_pipe_en", {31'd0, in_pipe_en}, 32'd1);
    tick();
    chk("single_in_ack", {30'd0, in_ack_p, in_ack_n}, 32'd1);
    chk("single_count1", {29'd0, fifo_count}, 32'd1);
    chk("single_no_reaccept", {31'd0, in_pipe_en}, 32'd0);
    tick();
    chk("single_out_rail", {30'd0, out_diff_pair_p, out_diff_pair_n}, 32'd1);
    chk("single_out_data", {16'd0, out_data}, 32'h0000A5A5);
    chk("single_empty", {31'd0, empty}, 32'd1);

    // Back-pressure: downstream ack frozen at current phase 0/1
    man_ack_p = 1'b0; man_ack_n = 1'b1; auto_ack = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_p = ~in_p; in_n = ~in_n; in_data = 16'(i);
      #1 chk("bp_accept", {31'd0, in_pipe_en}, 32'd1);
      tick();
    end
    chk("bp_full", {31'd0, full}, 32'd1);
    chk("bp_count", {29'd0, fifo_count}, 32'd4);
    chk("bp_out_data", {16'd0, out_data}, 32'd1);
    chk("bp_out_rail", {30'd0, out_diff_pair_p, out_diff_pair_n}, 32'd2);
    in_p = ~in_p; in_n = ~in_n; in_data = 16'h0006;
    #1 chk("bp_blocked", {31'd0, in_pipe_en}, 32'd0);
    tick();
    chk("bp_ack_held", {30'd0, in_ack_p, in_ack_n}, {30'd0, ~in_p, ~in_n});
    chk("bp_count_held", {29'd0, fifo_count}, 32'd4);
    man_ack_p = 1'b1; man_ack_n = 1'b0;
    #1 chk("bp_no_push_on_pop", {31'd0, in_pipe_en}, 32'd0);
    tick();
    chk("bp_pop_count", {29'd0, fifo_count}, 32'd3);
    chk("bp_pop_data", {16'd0, out_data}, 32'd2);
    chk("bp_now_accept", {31'd0, in_pipe_en}, 32'd1);
    tick();
    chk("bp_ack_after", {30'd0, in_ack_p, in_ack_n}, {30'd0, in_p, in_n});
    chk("bp_refull", {29'd0, fifo_count}, 32'd4);
    auto_ack = 1'b1;
    for (int i = 3; i <= 6; i++) begin
      tick();
      chk("bp_drain_order", {16'd0, out_data}, 32'(i));
    end
    chk("bp_drained", {31'd0, empty}, 32'd1);

    // Ordering and wrap with random downstream ack delay
    man_ack_p = out_diff_pair_p; man_ack_n = out_diff_pair_n; auto_ack = 1'b0;
    prev_p = out_diff_pair_p; snt = 0; rcv = 0; dly = 0; max_cnt = 0;
    for (int cyc = 0; cyc < 300 && rcv < 10; cyc++) begin
      if (out_diff_pair_p !== prev_p) begin
        chk("order_data", {16'd0, out_data}, 32'h10 + 32'(rcv));
        rcv++;
        prev_p = out_diff_pair_p;
        dly = $urandom_range(0, 3);
      end
      if (out_diff_pair_p !== man_ack_p) begin
        if (dly == 0) begin
          man_ack_p = out_diff_pair_p; man_ack_n = out_diff_pair_n;
        end else dly--;
      end
      if (snt < 10 && in_ack_p === in_p && in_ack_n === in_n) begin
        in_p = ~in_p; in_n = ~in_n; in_data = 16'h0010 + 16'(snt);
        snt++;
      end
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      tick();
    end
    chk("order_received", 32'(rcv), 32'd10);
    chk("order_max_count", {31'd0, max_cnt <= 4}, 32'd1);
    auto_ack = 1'b1;
    tick(); tick();
    chk("order_empty", {31'd0, empty}, 32'd1);

    // Partial rail: only p flips, held for 3 cycles
    in_p = ~in_p; in_data = 16'h5A5A;
    for (int i = 0; i < 3; i++) begin
      #1 chk("partial_no_en", {31'd0, in_pipe_en}, 32'd0);
      tick();
      chk("partial_no_push", {29'd0, fifo_count}, 32'd0);
    end
    in_n = ~in_n;
    #1 chk("partial_complete_en", {31'd0, in_pipe_en}, 32'd1);
    tick();
    chk("partial_ack", {30'd0, in_ack_p, in_ack_n}, {30'd0, in_p, in_n});
    tick();
    chk("partial_out_data", {16'd0, out_data}, 32'h00005A5A);

    // Reset mid-operation: 3 buffered plus one outstanding
    man_ack_p = out_diff_pair_p; man_ack_n = out_diff_pair_n; auto_ack = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_p = ~in_p; in_n = ~in_n; in_data = 16'h0020 + 16'(i);
      tick();
    end
    chk("mid_count3", {29'd0, fifo_count}, 32'd3);
    rsta = 1'b0; in_p = 1'b1; in_n = 1'b0; man_ack_p = 1'b1; man_ack_n = 1'b0;
    tick();
    chk_reset_state("mid_reset");
    rsta = 1'b1;
    tick(); tick(); tick();
    chk("mid_no_stale_data", {16'd0, out_data}, 32'd0);
    chk("mid_still_empty", {31'd0, empty}, 32'd1);
    chk("mid_rail_idle", {30'd0, out_diff_pair_p, out_diff_pair_n}, 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
